// File: rtl/xor_share_arb.sv
// Round-robin arbiter sharing one registered WIDTH-bit XOR datapath among NREQ requesters.
// Optional burst locking is compiled in with `define XOR_SHARE_ARB_LOCK_EN.
module xor_share_arb #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 4,
  parameter int IDW      = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
`ifdef XOR_SHARE_ARB_LOCK_EN
  input  logic [NREQ-1:0]       req_lock,
`endif
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);

  if (IDW != $clog2(NREQ) || LOCK_MAX < 1 || LOCK_MAX > 15) begin : g_param_err
    $error("xor_share_arb: illegal IDW or LOCK_MAX");
  end

  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [IDW-1:0]   res_id_q;
  logic [IDW-1:0]   last_grant_q;

  logic             accept;
  logic             rr_found;
  logic [IDW-1:0]   rr_winner;
  logic             win_found;
  logic [IDW-1:0]   winner;
  logic             xfer;

  assign accept = ~res_valid_q | res_ready;

  // Search from the slot after the last grant, wrapping modulo NREQ.
  always_comb begin
    int idx;
    rr_found  = 1'b0;
    rr_winner = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant_q) + k) % NREQ;
      if (!rr_found && req_valid[idx]) begin
        rr_found  = 1'b1;
        rr_winner = IDW'(idx);
      end
    end
  end

`ifdef XOR_SHARE_ARB_LOCK_EN
  logic [3:0]     lock_cnt_q, lock_cnt_d;
  logic           lock_act_q, lock_act_d;
  logic [IDW-1:0] lock_own_q, lock_own_d;
  logic           lock_hold;

  // The owner keeps the grant until its burst budget is spent.
  assign lock_hold = lock_act_q & req_valid[lock_own_q] & req_lock[lock_own_q] &
                     (lock_cnt_q < 4'(LOCK_MAX));
  assign winner    = lock_hold ? lock_own_q : rr_winner;
  assign win_found = lock_hold | rr_found;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    lock_act_d = lock_act_q;
    lock_own_d = lock_own_q;
    if (xfer) begin
      if (req_lock[winner]) begin
        lock_act_d = 1'b1;
        lock_own_d = winner;
        lock_cnt_d = lock_hold ? lock_cnt_q + 4'd1 : 4'd1;
      end else begin
        lock_act_d = 1'b0;
        lock_cnt_d = 4'd0;
      end
    end else if (accept) begin
      // Not stalled and nobody transferred: the owner has let go.
      lock_act_d = 1'b0;
      lock_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= 4'd0;
      lock_act_q <= 1'b0;
      lock_own_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_act_q <= lock_act_d;
      lock_own_q <= lock_own_d;
    end
  end
`else
  assign winner    = rr_winner;
  assign win_found = rr_found;
`endif

  assign xfer = rst_n & accept & win_found;

  always_comb begin
    req_ready = '0;
    if (xfer && req_valid[winner]) req_ready[winner] = 1'b1;
  end

  assign res_data_d = req_a[int'(winner)*WIDTH +: WIDTH] ^ req_b[int'(winner)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= '0;
      last_grant_q <= IDW'(NREQ - 1);
    end else if (xfer) begin
      res_valid_q  <= 1'b1;
      res_data_q   <= res_data_d;
      res_id_q     <= winner;
      last_grant_q <= winner;
    end else if (res_ready) begin
      res_valid_q  <= 1'b0;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = res_valid_q | (|req_valid);

endmodule

// File: tb/tb_xor_share_arb.sv
// Self-checking bench for xor_share_arb: directed vector table, reset corner cases,
// and randomized traffic against a pointer-based round-robin reference model.
module tb_xor_share_arb;

  localparam int NREQ = 4;
  localparam int WIDTH = 4;
  localparam int IDW = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_lock = '0;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  logic [WIDTH-1:0]      res_data;
  logic [IDW-1:0]        res_id;
  logic                  busy;

  xor_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .LOCK_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef XOR_SHARE_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          rst;
    logic [3:0]  v;
    logic [15:0] a;
    logic [15:0] b;
    bit          rr;
    logic [3:0]  er;
    bit          ev;
    logic [3:0]  ed;
    logic [1:0]  eid;
  } vec_t;

  vec_t tbl[17];

  // Called at posedge+1; leaves the bench at posedge+1 of the next cycle.
  task automatic apply_vec(input vec_t t, input int n);
    if (t.rst) begin
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
    end
    req_valid = t.v;
    req_a     = t.a;
    req_b     = t.b;
    res_ready = t.rr;
    #2;
    check($sformatf("tbl%0d_req_ready", n), 32'(req_ready), 32'(t.er));
    @(posedge clk);
    #1;
    check($sformatf("tbl%0d_res_valid", n), 32'(res_valid), 32'(t.ev));
    check($sformatf("tbl%0d_res_data", n), 32'(res_data), 32'(t.ed));
    check($sformatf("tbl%0d_res_id", n), 32'(res_id), 32'(t.eid));
  endtask

  // Reference model state
  int         m_last;
  bit         m_vld;
  logic [3:0] m_data;
  int         m_id;
  bit         pend[NREQ];
  logic [3:0] pa[NREQ];
  logic [3:0] pb[NREQ];

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_last = NREQ - 1;
    m_vld  = 1'b0;
    m_data = '0;
    m_id   = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1, 4'b0001, 16'h000A, 16'h0005, 1, 4'b0001, 1, 4'hF, 2'd0};
    tbl[1]  = '{0, 4'b0000, 16'h0000, 16'h0000, 1, 4'b0000, 0, 4'hF, 2'd0};
    tbl[2]  = '{1, 4'b1111, 16'h3210, 16'hFFFF, 1, 4'b0001, 1, 4'hF, 2'd0};
    tbl[3]  = '{0, 4'b1111, 16'h3210, 16'hFFFF, 1, 4'b0010, 1, 4'hE, 2'd1};
    tbl[4]  = '{0, 4'b1111, 16'h3210, 16'hFFFF, 1, 4'b0100, 1, 4'hD, 2'd2};
    tbl[5]  = '{0, 4'b1111, 16'h3210, 16'hFFFF, 1, 4'b1000, 1, 4'hC, 2'd3};
    tbl[6]  = '{0, 4'b1111, 16'h3210, 16'hFFFF, 1, 4'b0001, 1, 4'hF, 2'd0};
    tbl[7]  = '{0, 4'b1111, 16'h3210, 16'hFFFF, 1, 4'b0010, 1, 4'hE, 2'd1};
    tbl[8]  = '{0, 4'b1111, 16'h3210, 16'hFFFF, 1, 4'b0100, 1, 4'hD, 2'd2};
    tbl[9]  = '{0, 4'b1111, 16'h3210, 16'hFFFF, 1, 4'b1000, 1, 4'hC, 2'd3};
    tbl[10] = '{0, 4'b0100, 16'h3210, 16'hFFFF, 0, 4'b0000, 1, 4'hC, 2'd3};
    tbl[11] = '{0, 4'b0100, 16'h3210, 16'hFFFF, 0, 4'b0000, 1, 4'hC, 2'd3};
    tbl[12] = '{0, 4'b0100, 16'h3210, 16'hFFFF, 0, 4'b0000, 1, 4'hC, 2'd3};
    tbl[13] = '{0, 4'b0100, 16'h3210, 16'hFFFF, 1, 4'b0100, 1, 4'hD, 2'd2};
    tbl[14] = '{1, 4'b0010, 16'h3210, 16'hFFFF, 1, 4'b0010, 1, 4'hE, 2'd1};
    tbl[15] = '{0, 4'b0011, 16'h3210, 16'hFFFF, 1, 4'b0001, 1, 4'hF, 2'd0};
    tbl[16] = '{0, 4'b0011, 16'h3210, 16'hFFFF, 1, 4'b0010, 1, 4'hE, 2'd1};

    // Reset state, including req_ready held low while valid is asserted.
    req_valid = 4'b1111;
    res_ready = 1'b1;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 17; n++) apply_vec(tbl[n], n);

    // Asynchronous reset while a result is pending.
    check("pre_rst_res_valid", 32'(res_valid), 32'd1);
    req_valid = 4'b1111;
    req_a     = 16'h3210;
    req_b     = 16'hFFFF;
    res_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("async_rst_res_valid", 32'(res_valid), 32'd0);
    check("async_rst_req_ready", 32'(req_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("post_rst_res_id", 32'(res_id), 32'd0);
    check("post_rst_res_data", 32'(res_data), 32'hF);

    // Randomized traffic with requesters that hold their pair until accepted.
    pulse_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [NREQ-1:0] v;
      bit              rr;
      bit              acc;
      int              w;
      logic [NREQ-1:0] exp_ready;
      v = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          pa[i]   = 4'($urandom);
          pb[i]   = 4'($urandom);
        end
        v[i] = pend[i];
        req_a[i*WIDTH +: WIDTH] = pa[i];
        req_b[i*WIDTH +: WIDTH] = pb[i];
      end
      rr        = ($urandom_range(0, 3) != 0);
      req_valid = v;
      res_ready = rr;
      acc       = !m_vld || rr;
      w         = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && v[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
      exp_ready = '0;
      if (acc && w >= 0) exp_ready[w] = 1'b1;
      #2;
      check("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
      check("rnd_busy", 32'(busy), 32'(m_vld || (v != 0)));
      @(posedge clk);
      #1;
      if (acc && w >= 0) begin
        m_vld   = 1'b1;
        m_data  = pa[w] ^ pb[w];
        m_id    = w;
        m_last  = w;
        pend[w] = 1'b0;
      end else if (rr) begin
        m_vld = 1'b0;
      end
      check("rnd_res_valid", 32'(res_valid), 32'(m_vld));
      if (m_vld) begin
        check("rnd_res_data", 32'(res_data), 32'(m_data));
        check("rnd_res_id", 32'(res_id), 32'(m_id));
      end
    end

`ifdef XOR_SHARE_ARB_LOCK_EN
    begin
      int exp_g[8] = '{1, 1, 1, 1, 2, 1, 1, 2};
      pulse_reset();
      req_valid = 4'b0110;
      req_a     = 16'h3210;
      req_b     = 16'hFFFF;
      res_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
        logic [NREQ-1:0] eg;
        req_lock = (n < 7) ? 4'b0010 : 4'b0000;
        eg = '0;
        eg[exp_g[n]] = 1'b1;
        #2;
        check($sformatf("lock%0d_req_ready", n), 32'(req_ready), 32'(eg));
        @(posedge clk);
        #1;
      end
      req_lock = '0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xor_share_arb.md
Name: xor_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit XOR datapath (quad 2-input XOR function) among NREQ requesters.
- Each requester offers an operand pair through a valid/ready handshake.
- The block grants one requester per cycle, registers a^b together with the requester ID, and presents it on a single result port with backpressure.
- It sits between several client blocks and the shared XOR resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand/result width in bits.
- IDW, 2, ID width; must equal clog2(NREQ).
- LOCK_MAX, 4, maximum consecutive grants under lock (used only with XOR_SHARE_ARB_LOCK_EN; 1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  bit i: requester i has an operand pair.
- req_ready  out  NREQ  bit i: requester i's pair is accepted this cycle.
- req_a  in  NREQ*WIDTH  operand a; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b; same slicing as req_a.
- req_lock  in  NREQ  lock request; present only with XOR_SHARE_ARB_LOCK_EN.
- res_valid  out  1  result register full.
- res_ready  in  1  consumer accepts the result.
- res_data  out  WIDTH  registered a^b.
- res_id  out  IDW  index of the requester that produced res_data.
- busy  out  1  res_valid OR any req_valid.

Behaviour:
- Reset (async assert, sync-released by the system): res_valid=0, res_data=0, res_id=0, last_grant=NREQ-1, so requester 0 has first priority. All req_ready bits are 0 during reset.
- accept = ~res_valid | res_ready. The output register is free, or is drained in the same cycle.
- Arbitration is combinational. Search starts at (last_grant+1) mod NREQ, increments with wrap, and picks the first i with req_valid[i]=1.
- req_ready[i] = accept & (i == winner) & req_valid[i]. At most one bit is high.
- Transfer occurs on a cycle with req_valid[i]&req_ready[i]. At the next edge:
  - res_data <= req_a_i ^ req_b_i
  - res_id <= i
  - res_valid <= 1
  - last_grant <= i
- Latency is 1 cycle from handshake to res_valid.
- Throughput is one result per cycle while res_ready=1.
- res_valid&res_ready with no new transfer: res_valid <= 0; res_data and res_id hold their last values.
- res_valid=1 & res_ready=0:
  - all req_ready=0
  - res_data and res_id stable
  - last_grant unchanged
- No requests valid: last_grant unchanged; no grant issued.
- Requesters must hold req_valid and operands stable until ready. The arbiter does not enforce this.
- Fairness: with all NREQ requesters continuously valid and res_ready=1, grant order is 0,1,..,NREQ-1,0,…
- Reset asserted mid-operation: any pending result is discarded immediately and the pointer returns to NREQ-1.

Optional Feature:
XOR_SHARE_ARB_LOCK_EN
- Defined:
  - Adds the req_lock port and a burst counter (width 4).
  - If requester i transfers with req_lock[i]=1, it is the winner on following cycles while req_valid[i]=1 and req_lock[i]=1, overriding round-robin.
  - The counter counts consecutive locked transfers. Once LOCK_MAX transfers have completed, the lock is ignored for one arbitration and the search resumes from i+1.
  - The counter clears when the lock is dropped, valid drops, or another requester is granted.
  - Stall cycles (res_ready=0) neither count nor break the lock.
- Undefined: no req_lock port and no counter; pure round-robin as above.

Test Plan:
- Reset then req_valid=4'b0001, a0=4'hA, b0=4'h5, res_ready=1 -> req_ready=4'b0001 in cycle 0; next cycle res_valid=1, res_data=4'hF, res_id=0.
- All four valid with a_i=i, b_i=4'hF, res_ready=1 for 8 cycles -> res_id sequence 0,1,2,3,0,1,2,3; res_data = 4'hF,4'hE,4'hD,4'hC repeating.
- Result pending, res_ready=0 for 3 cycles with req 2 valid -> req_ready=0, res_data/res_id stable; on res_ready=1, req 2 is accepted in the same cycle (back-to-back, no bubble).
- last_grant=3, only req 1 valid -> req 1 granted. Then req 1 and req 0 valid -> req 0 is not granted before req 2/3 are considered; order is 0 next because search starts at 2 and wraps.
- Assert rst_n=0 while res_valid=1 -> res_valid=0 immediately (asynchronous); after release with all valid, first grant is 0.
- With XOR_SHARE_ARB_LOCK_EN and LOCK_MAX=4: req 1 locked and continuously valid, req 2 valid -> grants 1,1,1,1,2,1…; dropping req_lock[1] after 2 grants -> next grant is 2.
